// File: rtl/ram_read_ctrl_pkg.sv
// Shared defaults for the RAM read-side controller and the RAM instance it drives.
package ram_read_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_FIFO_DEPTH = 2;

  // Width of an occupancy count able to hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ram_2port.sv
// 1W/1R synchronous RAM: registered read with 1-cycle latency, read-before-write, no reset.
module ram_2port
  import ram_read_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write and registered read share the edge, so a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
    read_data <= mem[read_addr];
  end

endmodule

// File: rtl/rd_resp_fifo.sv
// Small in-order response buffer: register storage, async-reset pointers and count.
module rd_resp_fifo
  import ram_read_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // Data storage: written on push, never reset.
  // NOTE: storage is not reset; validity comes from count, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since depth is a power of two.
  // NOTE: state updates use <= so every register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head_data = mem[rd_ptr];

  // The credit rule upstream must make an unmatched push into a full buffer impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: rtl/ram_read_ctrl.sv
// Read-side initiator: issues handshaked reads, tracks the in-flight read, optionally
// forwards a same-cycle write, and buffers responses so backpressure never drops data.
module ram_read_ctrl
  import ram_read_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FWD_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  input  logic                  snoop_wr_en,
  input  logic [ADDR_WIDTH-1:0] snoop_wr_addr,
  input  logic [DATA_WIDTH-1:0] snoop_wr_data,
  output logic                  busy
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int OCC_W = CNT_W + 1;

  logic                  inflight_q;
  logic                  fwd_hit_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic                  issue;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CNT_W-1:0]      count;
  logic [OCC_W-1:0]      occupancy;

  // The RAM reads every cycle; only handshaked reads are tracked.
  assign ram_read_addr = req_addr;
  assign issue         = req_valid && req_ready;
  assign resp_valid    = (count != '0);
  assign pop           = resp_valid && resp_ready;
  assign busy          = inflight_q || resp_valid;
  assign resp_data     = resp_valid ? head_data : '0;
  assign push_data     = fwd_hit_q ? fwd_data_q : ram_read_data;

  // Credit: buffered + in-flight - leaving this cycle must leave room for one more read.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    req_ready = 1'b0;
    occupancy = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
    if (occupancy < OCC_W'(FIFO_DEPTH)) req_ready = 1'b1;
  end

  // In-flight flag and forward-hit flag for the read issued last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      fwd_hit_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      fwd_hit_q  <= (FWD_EN != 0) && issue && snoop_wr_en && (snoop_wr_addr == req_addr);
    end
  end

  // Captured write data; only consulted when fwd_hit_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (issue) fwd_data_q <= snoop_wr_data;
  end

  rd_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .count     (count)
  );

endmodule

// File: tb/tb_ram_read_ctrl.sv
// Bench: RAM plus two controllers (forwarding on and off) sharing one stimulus stream,
// checked against a cycle-level scoreboard model.
module tb_ram_read_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 64;
  localparam int DEPTH = 2;

  typedef struct {
    int          issue_cyc;
    logic [DW-1:0] d_fwd;
    logic [DW-1:0] d_nofwd;
  } sb_entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          resp_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] ram_rdata;

  logic          req_ready1, resp_valid1, busy1;
  logic [DW-1:0] resp_data1;
  logic [AW-1:0] ram_raddr1;
  logic          req_ready0, resp_valid0, busy0;
  logic [DW-1:0] resp_data0;
  logic [AW-1:0] ram_raddr0;

  sb_entry_t     sb[$];
  logic [DW-1:0] shadow [64];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_err = 0;
  int            n_pops = 0;
  int            n_issues = 0;

  always #5 clk = ~clk;

  ram_2port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_ram (
    .clk(clk), .write_en(wr_en), .write_addr(wr_addr), .write_data(wr_data),
    .read_addr(ram_raddr1), .read_data(ram_rdata)
  );

  ram_read_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1), .req_addr(req_addr),
    .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_data(resp_data1),
    .ram_read_addr(ram_raddr1), .ram_read_data(ram_rdata),
    .snoop_wr_en(wr_en), .snoop_wr_addr(wr_addr), .snoop_wr_data(wr_data), .busy(busy1)
  );

  ram_read_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWD_EN(0)) dut_nofwd (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0), .req_addr(req_addr),
    .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_data(resp_data0),
    .ram_read_addr(ram_raddr0), .ram_read_data(ram_rdata),
    .snoop_wr_en(wr_en), .snoop_wr_addr(wr_addr), .snoop_wr_data(wr_data), .busy(busy0)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample and check at the falling edge, update the model, then
  // return 1 time unit after the rising edge so the caller can drive the next inputs.
  task automatic tick();
    int        ncomplete;
    bit        inflight;
    bit        exp_valid;
    bit        exp_pop;
    bit        exp_ready;
    sb_entry_t e;
    @(negedge clk);
    ncomplete = 0;
    inflight  = 1'b0;
    foreach (sb[i]) begin
      if (sb[i].issue_cyc <= cyc - 2) ncomplete++;
      else inflight = 1'b1;
    end
    exp_valid = (ncomplete != 0);
    exp_pop   = exp_valid && resp_ready;
    exp_ready = (ncomplete + int'(inflight) - int'(exp_pop)) < DEPTH;
    check("resp_valid",       DW'(resp_valid1), DW'(exp_valid));
    check("resp_valid_nofwd", DW'(resp_valid0), DW'(exp_valid));
    check("req_ready",        DW'(req_ready1),  DW'(exp_ready));
    check("req_ready_nofwd",  DW'(req_ready0),  DW'(exp_ready));
    check("busy",             DW'(busy1),       DW'(inflight || exp_valid));
    check("busy_nofwd",       DW'(busy0),       DW'(inflight || exp_valid));
    if (req_valid) begin
      check("ram_read_addr",       DW'(ram_raddr1), DW'(req_addr));
      check("ram_read_addr_nofwd", DW'(ram_raddr0), DW'(req_addr));
    end
    if (exp_valid) begin
      check("resp_data",       resp_data1, sb[0].d_fwd);
      check("resp_data_nofwd", resp_data0, sb[0].d_nofwd);
    end else begin
      check("resp_data_idle", resp_data1, '0);
    end
    if (exp_pop) begin
      void'(sb.pop_front());
      n_pops++;
    end
    if (req_valid && exp_ready && rst_n) begin
      e.issue_cyc = cyc;
      e.d_nofwd   = shadow[req_addr];
      e.d_fwd     = (wr_en && wr_addr == req_addr) ? wr_data : shadow[req_addr];
      sb.push_back(e);
      n_issues++;
    end
    if (wr_en) shadow[wr_addr] = wr_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    req_addr   = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
  endtask

  task automatic drain(input string tag);
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    wr_en      = 1'b0;
    for (int k = 0; k < 12 && sb.size() != 0; k++) tick();
    check(tag, DW'(sb.size()), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i0;
    int p0;
    rst_n      = 1'b0;
    resp_ready = 1'b0;
    idle_inputs();

    // 1: reset state
    #1;
    check("rst_resp_valid", DW'(resp_valid1), '0);
    check("rst_busy",       DW'(busy1),       '0);
    check("rst_req_ready",  DW'(req_ready1),  DW'(1));
    check("rst_resp_data",  resp_data1,       '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Preload the RAM through its write port
    for (int a = 0; a < 64; a++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = (a == 5) ? 64'hA5 : (a == 9) ? 64'h11 : 64'h1000_0000_0000_0000 + 64'(a) * 64'h0101_0101;
      tick();
    end
    idle_inputs();
    tick();

    // 1: single read of addr 5, response two cycles after issue
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 6'd5;
    tick();
    req_valid = 1'b0;
    tick();
    check("t1_valid_t2", DW'(resp_valid1), DW'(1));
    check("t1_data",     resp_data1,       64'hA5);
    drain("t1_drain");

    // 2: streaming 0..63
    p0 = n_pops;
    i0 = n_issues;
    for (int a = 0; a < 64; a++) begin
      req_valid = 1'b1;
      req_addr  = AW'(a);
      tick();
    end
    check("stream_accepts", DW'(n_issues - i0), DW'(64));
    drain("stream_drain");
    check("stream_responses", DW'(n_pops - p0), DW'(64));

    // 3: backpressure
    resp_ready = 1'b0;
    i0 = n_issues;
    p0 = n_pops;
    for (int k = 0; k < 4; k++) begin
      req_valid = 1'b1;
      req_addr  = AW'(20 + n_issues - i0);
      tick();
    end
    check("bp_accepts", DW'(n_issues - i0), DW'(2));
    check("bp_ready_low", DW'(req_ready1), '0);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    tick();
    check("bp_responses", DW'(n_pops - p0), DW'(2));
    check("bp_ready_back", DW'(req_ready1), DW'(1));
    drain("bp_drain");

    // 4: forwarding, same-cycle write
    req_valid = 1'b1;
    req_addr  = 6'd9;
    wr_en     = 1'b1;
    wr_addr   = 6'd9;
    wr_data   = 64'h22;
    tick();
    idle_inputs();
    tick();
    check("fwd_same_cycle",   resp_data1, 64'h22);
    check("nofwd_same_cycle", resp_data0, 64'h11);
    drain("fwd_drain");
    // restore 0x11, then write one cycle after issue
    wr_en   = 1'b1;
    wr_addr = 6'd9;
    wr_data = 64'h11;
    tick();
    idle_inputs();
    req_valid = 1'b1;
    req_addr  = 6'd9;
    tick();
    req_valid = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = 6'd9;
    wr_data   = 64'h33;
    tick();
    idle_inputs();
    check("fwd_later_write",   resp_data1, 64'h11);
    check("nofwd_later_write", resp_data0, 64'h11);
    drain("fwd2_drain");

    // 5: reset with one read in flight and one buffered
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 6'd30;
    tick();
    req_addr = 6'd31;
    tick();
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_resp_valid", DW'(resp_valid1), '0);
    check("midrst_busy",       DW'(busy1),       '0);
    check("midrst_req_ready",  DW'(req_ready1),  DW'(1));
    tick();
    tick();
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    tick();
    tick();
    check("postrst_no_stale", DW'(resp_valid1), '0);
    req_valid = 1'b1;
    req_addr  = 6'd5;
    tick();
    req_valid = 1'b0;
    tick();
    check("postrst_data", resp_data1, 64'hA5);
    drain("postrst_drain");

    // 6: random traffic against the model
    for (int k = 0; k < 400; k++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_addr   = AW'($urandom_range(0, 7));
      resp_ready = ($urandom_range(0, 9) < 7);
      wr_en      = ($urandom_range(0, 1) != 0);
      wr_addr    = AW'($urandom_range(0, 7));
      wr_data    = {$urandom, $urandom};
      tick();
    end
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
